// File: rtl/regfile_dma.sv
// Register-file DMA engine: streams a contiguous register range out (dump)
// or fills it from an input stream (load), one register per beat.
module regfile_dma #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_first,
  input  logic [ADDR_W-1:0] cmd_last,
  // dump stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  // load stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  // register-file ports
  output logic [ADDR_W-1:0] rf_read_register_1,
  input  logic [DATA_W-1:0] rf_read_data_1,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_register,
  output logic [DATA_W-1:0] rf_write_data,
  // status
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DUMP_RD = 3'd1,
    DUMP_TX = 3'd2,
    LOAD_RX = 3'd3,
    LOAD_WR = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic              op_reg, op_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] last_reg, last_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              at_last;

  assign at_last = (ptr_reg == last_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= 1'b0;
      ptr_reg      <= '0;
      last_reg     <= '0;
      out_data_reg <= '0;
      out_addr_reg <= '0;
      wr_data_reg  <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      op_reg       <= op_next;
      ptr_reg      <= ptr_next;
      last_reg     <= last_next;
      out_data_reg <= out_data_next;
      out_addr_reg <= out_addr_next;
      wr_data_reg  <= wr_data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    op_next            = op_reg;
    ptr_next           = ptr_reg;
    last_next          = last_reg;
    out_data_next      = out_data_reg;
    out_addr_next      = out_addr_reg;
    wr_data_next       = wr_data_reg;
    done_next          = 1'b0;
    err_next           = 1'b0;
    cmd_ready          = 1'b0;
    out_valid          = 1'b0;
    in_ready           = 1'b0;
    rf_reg_write       = 1'b0;
    rf_write_register  = '0;
    rf_write_data      = '0;
    rf_read_register_1 = ptr_reg;

    case (state_reg)
      IDLE: begin
        // Held low during reset so nothing can be accepted while rst_n is asserted.
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          op_next   = cmd_op;
          ptr_next  = cmd_first;
          last_next = cmd_last;
          if (cmd_first > cmd_last) begin
            err_next = 1'b1;
          end else if (cmd_op) begin
            state_next = LOAD_RX;
          end else begin
            state_next = DUMP_RD;
          end
        end
      end

      DUMP_RD: begin
        out_data_next = rf_read_data_1;
        out_addr_next = ptr_reg;
        state_next    = DUMP_TX;
      end

      DUMP_TX: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (at_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            ptr_next   = ptr_reg + ADDR_W'(1);
            state_next = DUMP_RD;
          end
        end
      end

      LOAD_RX: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_data_next = in_data;
          state_next   = LOAD_WR;
        end
      end

      LOAD_WR: begin
        // r0 is hard-wired zero: the word is consumed but never written.
        rf_write_register = ptr_reg;
        rf_write_data     = wr_data_reg;
        rf_reg_write      = (ptr_reg != '0);
        if (at_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          ptr_next   = ptr_reg + ADDR_W'(1);
          state_next = LOAD_RX;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign out_data = out_data_reg;
  assign out_addr = out_addr_reg;

endmodule

// File: tb/tb_regfile_dma.sv
// Directed bench for regfile_dma with a behavioural 8x16 register file
// and a negedge monitor that logs stream beats and status pulses.
module tb_regfile_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [2:0]  cmd_first, cmd_last;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_addr;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [2:0]  rf_read_register_1;
  logic [15:0] rf_read_data_1;
  logic        rf_reg_write;
  logic [2:0]  rf_write_register;
  logic [15:0] rf_write_data;
  logic        busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_dma #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_first(cmd_first), .cmd_last(cmd_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_read_register_1(rf_read_register_1), .rf_read_data_1(rf_read_data_1),
    .rf_reg_write(rf_reg_write), .rf_write_register(rf_write_register),
    .rf_write_data(rf_write_data),
    .busy(busy), .done(done), .err(err)
  );

  // Register file model
  logic [15:0] rf [8];
  logic        rf_load;
  assign rf_read_data_1 = rf[rf_read_register_1];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'(i);
    end else if (rf_reg_write) begin
      rf[rf_write_register] <= rf_write_data;
    end
  end

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  beat_addr [$];
  logic [15:0] beat_data [$];
  int          beat_cyc  [$];
  int done_cnt, err_cnt, ov_cnt, wr_cnt, r0_wr_cnt, busy_cnt, both_cnt;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beat_addr.push_back(out_addr);
      beat_data.push_back(out_data);
      beat_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (out_valid) ov_cnt++;
    if (rf_reg_write) wr_cnt++;
    if (rf_reg_write && rf_write_register == 3'd0) r0_wr_cnt++;
    if (busy) busy_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic clear_mon();
    beat_addr.delete();
    beat_data.delete();
    beat_cyc.delete();
    done_cnt = 0; err_cnt = 0; ov_cnt = 0; wr_cnt = 0;
    r0_wr_cnt = 0; busy_cnt = 0; both_cnt = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic issue(input logic op, input logic [2:0] f, input logic [2:0] l);
    cmd_op = op; cmd_first = f; cmd_last = l; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; break; end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    bit seen = 1'b0;
    in_data = w; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin seen = 1'b1; break; end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL in_ready_timeout: word %h got in_ready=0, required 1", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rf_load = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, out_valid, in_ready, rf_reg_write, done, err, cmd_ready} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {busy,ov,ir,we,done,err,cmd_ready}=%b required 0000000",
               {busy, out_valid, in_ready, rf_reg_write, done, err, cmd_ready});
    end
    tests_run++;
    if ({out_data, out_addr, rf_write_register, rf_write_data} !== 38'b0) begin
      tests_failed++;
      $display("FAIL reset_data: od=%h oa=%0d wa=%0d wd=%h required all 0",
               out_data, out_addr, rf_write_register, rf_write_data);
    end
    repeat (3) @(posedge clk);
    #1 rf_load = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready_held: cmd_ready=%b required 0", cmd_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_dump_all();
    clear_mon();
    out_ready = 1'b1;
    issue(1'b0, 3'd0, 3'd7);
    // a bad command presented while busy must be ignored
    cmd_first = 3'd5; cmd_last = 3'd3; cmd_valid = 1'b1;
    tests_run++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_busy: busy=%b cmd_ready=%b required 1 0", busy, cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(40, "dump_all");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (beat_addr.size() != 8) begin
      tests_failed++;
      $display("FAIL dump_all_count: beats=%0d required 8", beat_addr.size());
    end
    for (int i = 0; i < 8 && i < beat_addr.size(); i++) begin
      tests_run++;
      if (beat_addr[i] !== 3'(i) || beat_data[i] !== 16'(i)) begin
        tests_failed++;
        $display("FAIL dump_all_beat%0d: (addr,data)=(%0d,%h) required (%0d,%h)",
                 i, beat_addr[i], beat_data[i], i, 16'(i));
      end
      if (i > 0) begin
        tests_run++;
        if (beat_cyc[i] - beat_cyc[i-1] != 2) begin
          tests_failed++;
          $display("FAIL dump_all_spacing%0d: gap=%0d required 2", i, beat_cyc[i] - beat_cyc[i-1]);
        end
      end
    end
    tests_run++;
    if (done_cnt != 1 || err_cnt != 0 || both_cnt != 0) begin
      tests_failed++;
      $display("FAIL dump_all_pulses: done=%0d err=%0d both=%0d required 1 0 0",
               done_cnt, err_cnt, both_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit hit = 1'b0;
    clear_mon();
    out_ready = 1'b1;
    issue(1'b0, 3'd0, 3'd7);
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_addr == 3'd3) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL bp_reach_addr3: addr 3 beat not presented");
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'h0003 || out_addr !== 3'd3) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: ov=%b data=%h addr=%0d required 1 0003 3",
                 i, out_valid, out_data, out_addr);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(40, "bp");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (beat_addr.size() != 8 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL bp_count: beats=%0d done=%0d required 8 1", beat_addr.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < beat_addr.size(); i++) begin
      tests_run++;
      if (beat_addr[i] !== 3'(i) || beat_data[i] !== 16'(i)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: (addr,data)=(%0d,%h) required (%0d,%h)",
                 i, beat_addr[i], beat_data[i], i, 16'(i));
      end
    end
  endtask

  task automatic test_bad_range();
    clear_mon();
    issue(1'b0, 3'd5, 3'd3);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_range_err: err=%b busy=%b done=%b required 1 0 0", err, busy, done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_range_pulse_width: err=%b required 0", err);
    end
    repeat (4) @(posedge clk); #1;
    tests_run++;
    if (err_cnt != 1 || busy_cnt != 0 || ov_cnt != 0 || wr_cnt != 0) begin
      tests_failed++;
      $display("FAIL bad_range_quiet: err=%0d busy=%0d ov=%0d wr=%0d required 1 0 0 0",
               err_cnt, busy_cnt, ov_cnt, wr_cnt);
    end
  endtask

  task automatic test_load();
    clear_mon();
    out_ready = 1'b1;
    issue(1'b1, 3'd2, 3'd4);
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    send_word(16'hCCCC);
    wait_done(20, "load");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (wr_cnt != 3 || done_cnt != 1 || rf[1] !== 16'd1 || rf[5] !== 16'd5) begin
      tests_failed++;
      $display("FAIL load_writes: wr=%0d done=%0d r1=%h r5=%h required 3 1 0001 0005",
               wr_cnt, done_cnt, rf[1], rf[5]);
    end
    clear_mon();
    issue(1'b0, 3'd2, 3'd4);
    wait_done(20, "load_dump");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (beat_data.size() != 3) begin
      tests_failed++;
      $display("FAIL load_dump_count: beats=%0d required 3", beat_data.size());
    end else if (beat_data[0] !== 16'hAAAA || beat_data[1] !== 16'hBBBB || beat_data[2] !== 16'hCCCC
                 || beat_addr[0] !== 3'd2 || beat_addr[2] !== 3'd4) begin
      tests_failed++;
      $display("FAIL load_dump_data: %h@%0d %h %h@%0d required AAAA@2 BBBB CCCC@4",
               beat_data[0], beat_addr[0], beat_data[1], beat_data[2], beat_addr[2]);
    end
  endtask

  task automatic test_r0();
    clear_mon();
    issue(1'b1, 3'd0, 3'd1);
    send_word(16'h1234);
    send_word(16'h5678);
    wait_done(20, "r0_load");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (r0_wr_cnt != 0 || wr_cnt != 1) begin
      tests_failed++;
      $display("FAIL r0_no_write: r0_writes=%0d writes=%0d required 0 1", r0_wr_cnt, wr_cnt);
    end
    clear_mon();
    issue(1'b0, 3'd0, 3'd1);
    wait_done(20, "r0_dump");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (beat_data.size() != 2) begin
      tests_failed++;
      $display("FAIL r0_dump_count: beats=%0d required 2", beat_data.size());
    end else if (beat_data[0] !== 16'h0000 || beat_data[1] !== 16'h5678) begin
      tests_failed++;
      $display("FAIL r0_dump_data: %h %h required 0000 5678", beat_data[0], beat_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    issue(1'b1, 3'd2, 3'd4);
    send_word(16'h1111);
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_in_load_rx: in_ready=%b required 1", in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, out_valid, in_ready, rf_reg_write, done, err, cmd_ready} !== 7'b0 ||
        {out_data, out_addr, rf_write_register, rf_write_data} !== 38'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: ctrl=%b od=%h oa=%0d wa=%0d wd=%h required all 0",
               {busy, out_valid, in_ready, rf_reg_write, done, err, cmd_ready},
               out_data, out_addr, rf_write_register, rf_write_data);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (rf[2] !== 16'h1111 || rf[3] !== 16'hBBBB || done_cnt != 0 || wr_cnt != 1) begin
      tests_failed++;
      $display("FAIL mid_reset_state: r2=%h r3=%h done=%0d wr=%0d required 1111 BBBB 0 1",
               rf[2], rf[3], done_cnt, wr_cnt);
    end
    clear_mon();
    issue(1'b0, 3'd2, 3'd3);
    wait_done(20, "mid_dump");
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (beat_data.size() != 2) begin
      tests_failed++;
      $display("FAIL mid_dump_count: beats=%0d required 2", beat_data.size());
    end else if (beat_data[0] !== 16'h1111 || beat_data[1] !== 16'hBBBB) begin
      tests_failed++;
      $display("FAIL mid_dump_data: %h %h required 1111 BBBB", beat_data[0], beat_data[1]);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_last = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    rst_n = 1'b1; rf_load = 1'b1;
    clear_mon();
    test_reset();
    test_dump_all();
    test_backpressure();
    test_bad_range();
    test_load();
    test_r0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_dma.md
REGFILE_DMA -- requirements
Module: regfile_dma

Interface
REQ-001 Parameters SHALL be DATA_W, default 16, register data width; ADDR_W, default 3, register address width (8 registers).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1 / cmd_ready  output  1  command handshake.
REQ-005 cmd_op  input  1  command operation: 0 = dump (read registers out), 1 = load (write registers in).
REQ-006 cmd_first  input  ADDR_W / cmd_last  input  ADDR_W  inclusive register range.
REQ-007 out_valid  output  1 / out_ready  input  1 / out_data  output  DATA_W / out_addr  output  ADDR_W  dump stream.
REQ-008 in_valid  input  1 / in_ready  output  1 / in_data  input  DATA_W  load stream.
REQ-009 rf_read_register_1  output  ADDR_W / rf_read_data_1  input  DATA_W  register-file read port (combinational read on the register-file side).
REQ-010 rf_reg_write  output  1 / rf_write_register  output  ADDR_W / rf_write_data  output  DATA_W  register-file write port (register file samples on the rising edge of clk).
REQ-011 busy  output  1  high in any state except IDLE; done  output  1  one-cycle completion pulse; err  output  1  one-cycle rejected-command pulse.

Function
REQ-012 FSM states SHALL be IDLE, DUMP_RD, DUMP_TX, LOAD_RX, LOAD_WR.
REQ-013 IDLE: cmd_ready = 1; all other handshake outputs = 0.
REQ-014 Command acceptance (cmd_valid & cmd_ready) SHALL latch op, first, last and load ptr <= first.
REQ-015 Acceptance with first > last SHALL pulse err for 1 cycle, stay in IDLE, and cause no port activity.
REQ-016 Otherwise, acceptance SHALL transition to DUMP_RD (op = 0) or LOAD_RX (op = 1).
REQ-017 DUMP_RD: rf_read_register_1 = ptr; next edge SHALL capture out_data <= rf_read_data_1 and out_addr <= ptr, then go to DUMP_TX.
REQ-018 DUMP_TX: out_valid = 1; out_data and out_addr SHALL be held stable until out_ready.
REQ-019 On out_valid & out_ready: if ptr == last, go to IDLE and pulse done; else ptr <= ptr + 1 and return to DUMP_RD.
REQ-020 Dump throughput SHALL be 1 beat per 2 cycles when out_ready is held high.
REQ-021 LOAD_RX: in_ready = 1; on in_valid & in_ready, capture in_data into the write-data register and go to LOAD_WR.
REQ-022 LOAD_WR (exactly 1 cycle): rf_write_register = ptr, rf_write_data = captured word, rf_reg_write = 1 unless ptr == 0.
REQ-023 A load word addressed to r0 SHALL be consumed and discarded, with no write asserted.
REQ-024 After LOAD_WR: if ptr == last, go to IDLE and pulse done; else ptr <= ptr + 1 and return to LOAD_RX.
REQ-025 ptr SHALL never wrap; range termination by ptr == last, including last = 7, SHALL prevent 7 -> 0 wrap.
REQ-026 rf_reg_write SHALL be 0 in every state except LOAD_WR.
REQ-027 cmd_ready SHALL be 0 while busy; cmd_valid while busy SHALL be ignored.
REQ-028 done and err SHALL never be asserted in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, ptr 0, and all of: out_valid, in_ready, rf_reg_write, done, err, busy, out_data, out_addr, rf_write_register, rf_write_data = 0.
REQ-030 cmd_ready SHALL be 0 while rst_n is low and 1 from the first cycle after rst_n deasserts.
REQ-031 Reset mid-operation SHALL abort the operation; no pending write is issued and no done pulse is generated.

Verification
REQ-032 Register file initialised to ri = i; dump 0..7 with out_ready = 1 -> 8 beats (addr, data) = (0,0)..(7,7) at 2-cycle spacing, single done pulse.
REQ-033 Load 2..4 with 0xAAAA, 0xBBBB, 0xCCCC, then dump 2..4 -> 0xAAAA, 0xBBBB, 0xCCCC; r1 and r5 unchanged (1, 5).
REQ-034 Load 0..1 with 0x1234, 0x5678 -> rf_reg_write never high with address 0; dump 0..1 -> 0x0000, 0x5678.
REQ-035 Dump 0..7, out_ready low for 5 cycles at beat addr 3 -> out_valid held, out_data = 0x0003 stable, no beat lost or duplicated.
REQ-036 Command first = 5, last = 3 -> err pulse 1 cycle, busy stays 0, no out_valid or rf_reg_write.
REQ-037 rst_n low in LOAD_RX after 1 word written to r2 -> outputs 0 immediately, r2 keeps the new value, r3 unchanged; a new command is accepted after reset release.
